hazard_controller: RTL

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Consumes the decoded control bits of the ID and EX instructions (memtoreg, regwrite, branch outcome, multiply select).
- Drives the pipeline-register enables and bubble/flush controls.
- Handles three cases: load-use stalls, multi-cycle MUL occupancy of the ALU, and taken-branch/jump redirect flushes.

---
 rtl/hazard_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, multi-cycle MUL occupancy, redirect flushes.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_controller #(
  parameter int MUL_LAT = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic              ex_is_mul,
  input  logic              ex_redirect,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_hold,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              exmem_bubble,
  output logic              mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_loaduse_cnt,
  output logic [31:0]       perf_mul_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MUL_WAIT = 1'b1;
  localparam logic       MUL_EN   = (MUL_LAT > 1);
  // Wait-state count; unused when MUL_LAT is 1 because mul_go never fires.
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);

  logic [0:0] state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       load_use_s;
  logic       mul_go_s;
  logic       lu_stall_s;
  logic       mul_stall_s;
  logic       flush_acc_s;

  assign load_use_s = id_valid & ex_valid & ex_memtoreg & ex_regwrite & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mul_go_s   = ex_valid & ex_is_mul & MUL_EN;

  // Next-state and output decode; everything is forced low while rst is high.
  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;
    lu_stall_s   = 1'b0;
    mul_stall_s  = 1'b0;
    flush_acc_s  = 1'b0;
    if (rst) begin
      state_d   = RUN;
      mul_cnt_d = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_acc_s = 1'b1;
          end else if (mul_go_s) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            mul_stall_s  = 1'b1;
            mul_cnt_d    = MUL_INIT;
            state_d      = MUL_WAIT;
          end else if (load_use_s) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            lu_stall_s  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MUL_WAIT: begin
          // EX holds the MUL here, so redirect and load-use inputs are meaningless.
          mul_busy = 1'b1;
          if (mul_cnt_q != 4'd0) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            mul_stall_s  = 1'b1;
            mul_cnt_d    = mul_cnt_q - 4'd1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d   = RUN;
          mul_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // State and MUL countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_mul_q, perf_fl_q;

  // Event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q  <= 32'd0;
      perf_mul_q <= 32'd0;
      perf_fl_q  <= 32'd0;
    end else begin
      perf_lu_q  <= perf_lu_q  + {31'd0, lu_stall_s};
      perf_mul_q <= perf_mul_q + {31'd0, mul_stall_s};
      perf_fl_q  <= perf_fl_q  + {31'd0, flush_acc_s};
    end
  end

  assign perf_loaduse_cnt = perf_lu_q;
  assign perf_mul_cnt     = perf_mul_q;
  assign perf_flush_cnt   = perf_fl_q;
`endif

endmodule
